// File: rtl/test1_stim_player.sv
// Stimulus sequencer feeding test1: FIFO-buffered entries replayed
// cycle-exactly, each held for rpt+1 cycles.
module test1_stim_player #(
  parameter int DEPTH = 8,
  parameter int RPT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_in1,
  input  logic                     s_in2,
  input  logic                     s_in3,
  input  logic [RPT_W-1:0]         s_rpt,
  input  logic                     s_last,
  input  logic                     start,
  input  logic                     abort,
  output logic [7:0]               stim_in1,
  output logic                     stim_in2,
  output logic                     stim_in3,
  output logic                     stim_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [7:0]       in1;
    logic             in2;
    logic             in3;
    logic [RPT_W-1:0] rpt;
    logic             last;
  } ent_t;

  ent_t             mem [DEPTH];
  ent_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [RPT_W-1:0] hold;
  logic             cur_last;
  state_t           state;
  state_t           state_nx;
  logic             push;
  logic             pop;
  logic             fin;
  logic             starve;

  assign s_ready = (fifo_count < CW'(DEPTH)) && !abort;
  assign push    = s_valid && s_ready;
  assign head    = mem[rd_ptr];
  assign busy    = (state != IDLE);

  // Entry storage; flushing only moves pointers, so no reset needed
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{in1: s_in1, in2: s_in2, in3: s_in3,
                       rpt: s_rpt, last: s_last};
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and per-cycle replay decisions; abort overrides all
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    fin      = 1'b0;
    starve   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (hold == '0) begin
          if (stim_valid && cur_last) begin
            fin      = 1'b1;
            state_nx = IDLE;
          end else if (fifo_count != '0) begin
            pop = 1'b1;
          end else begin
            starve = 1'b1;
          end
        end
      end
    endcase
    if (abort) begin
      state_nx = IDLE;
      pop      = 1'b0;
      fin      = 1'b0;
      starve   = 1'b0;
    end
  end

  // FIFO bookkeeping, hold counter and registered stimulus outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hold       <= '0;
      cur_last   <= 1'b0;
      stim_in1   <= '0;
      stim_in2   <= 1'b0;
      stim_in3   <= 1'b0;
      stim_valid <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hold       <= '0;
      cur_last   <= 1'b0;
      stim_in1   <= '0;
      stim_in2   <= 1'b0;
      stim_in3   <= 1'b0;
      stim_valid <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done <= fin;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        stim_in1   <= head.in1;
        stim_in2   <= head.in2;
        stim_in3   <= head.in3;
        hold       <= head.rpt;
        cur_last   <= head.last;
        stim_valid <= 1'b1;
      end else if (starve) begin
        underrun   <= 1'b1;
        stim_valid <= 1'b0;
      end else if (fin) begin
        stim_valid <= 1'b0;
        cur_last   <= 1'b0;
      end else if (state == RUN && hold != '0) begin
        hold <= hold - RPT_W'(1);
      end
    end
  end

endmodule
